// File: rtl/regfile_sb.sv
// regfile_sb: CPU register file with two combinational read ports and one
// synchronous write port. It has an optional hardwired zero register, an
// optional write-to-read bypass, and a per-register scoreboard that decode
// uses to stall on RAW hazards.
module regfile_sb #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic             pend1,
  output logic             pend2
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             wr_ok;
  logic             iss_ok;
  logic             rd1_ok;
  logic             rd2_ok;

  // An address is usable if it names a real register that is not the hardwired zero
  function automatic logic usable(input logic [AW-1:0] a);
    return (32'(a) < DEPTH_U) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = we && usable(wa);
  assign iss_ok = iss_en && usable(iss_addr);
  assign rd1_ok = usable(ra1);
  assign rd2_ok = usable(ra2);

  // Register storage: cleared on reset, written on retire when the target is usable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // Scoreboard: retire clears, issue sets; the issue comes second so a new
  // producer supersedes one that retires to the same register on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (wr_ok) begin
        pending[wa] <= 1'b0;
      end
      if (iss_ok) begin
        pending[iss_addr] <= 1'b1;
      end
    end
  end

  // Read ports: unusable addresses read 0; a same-cycle write is forwarded when
  // bypassing is enabled and then also hides the pending bit it is about to clear
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (rd1_ok) begin
      if ((BYPASS != 0) && wr_ok && (wa == ra1)) begin
        rd1 = wd;
      end else begin
        rd1   = regs[ra1];
        pend1 = pending[ra1];
      end
    end
    if (rd2_ok) begin
      if ((BYPASS != 0) && wr_ok && (wa == ra2)) begin
        rd2 = wd;
      end else begin
        rd2   = regs[ra2];
        pend2 = pending[ra2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two instances in parallel, the default configuration
// (A: DEPTH=32, zero register, bypass) and a contrasting one (B: DEPTH=24,
// no zero register, no bypass), against hand-computed vectors and a small model.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, iss_addr;
  logic [63:0] wd;
  logic        we, iss_en;
  logic [63:0] rd1a, rd2a, rd1b, rd2b;
  logic        pend1a, pend2a, pend1b, pend2b;

  int tests;
  int failed;

  regfile_sb dut_a (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1a), .rd2(rd2a),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend1(pend1a), .pend2(pend2a)
  );

  regfile_sb #(.WIDTH(64), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1b), .rd2(rd2b),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .pend1(pend1b), .pend2(pend2b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] a1, a2;
    logic        ap1, ap2;
    logic [63:0] b1, b2;
    logic        bp1, bp2;
  } vec_t;

  vec_t vecs [17];

  logic [63:0] m_ra [32];
  logic        m_pa [32];
  logic [63:0] m_rb [32];
  logic        m_pb [32];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [63:0] d,
                               input logic i, input logic [4:0] ia, input logic [4:0] r1,
                               input logic [4:0] r2);
    we = w; wa = a; wd = d; iss_en = i; iss_addr = ia; ra1 = r1; ra2 = r2;
  endtask

  task automatic checkOutput(input string name,
                             input logic [63:0] ea1, input logic [63:0] ea2,
                             input logic eap1, input logic eap2,
                             input logic [63:0] eb1, input logic [63:0] eb2,
                             input logic ebp1, input logic ebp2);
    tests++;
    if ({rd1a, rd2a, pend1a, pend2a, rd1b, rd2b, pend1b, pend2b} !==
        {ea1, ea2, eap1, eap2, eb1, eb2, ebp1, ebp2}) begin
      failed++;
      if (failed <= 20)
        $display("[TB] FAIL %s: got A %h %h %b%b B %h %h %b%b, want A %h %h %b%b B %h %h %b%b",
                 name, rd1a, rd2a, pend1a, pend2a, rd1b, rd2b, pend1b, pend2b,
                 ea1, ea2, eap1, eap2, eb1, eb2, ebp1, ebp2);
    end
  endtask

  function automatic void modelRead(input int depth, input int zr, input int byp,
                                    input logic [63:0] mr [32], input logic mp [32],
                                    input logic [4:0] ra, output logic [63:0] d,
                                    output logic p);
    d = '0;
    p = 1'b0;
    if (int'(ra) >= depth || (zr != 0 && ra == 0)) return;
    if (byp != 0 && we && wa == ra && int'(wa) < depth && !(zr != 0 && wa == 0)) begin
      d = wd;
      return;
    end
    d = mr[ra];
    p = mp[ra];
  endfunction

  function automatic logic [4:0] randAddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      m_ra[i] = '0; m_pa[i] = 1'b0; m_rb[i] = '0; m_pb[i] = 1'b0;
    end
  endtask

  // Main test sequence
  initial begin
    logic [63:0] e1a, e2a, e1b, e2b;
    logic        q1a, q2a, q1b, q2b;
    tests = 0;
    failed = 0;

    //              we wa  wd        iss ia  r1  r2   A: rd1       rd2       p1 p2   B: rd1       rd2       p1 p2
    vecs[0]  = '{1, 3,  64'h1234, 0, 0,  3,  3,  64'h1234, 64'h1234, 0, 0, 64'h0,    64'h0,    0, 0};
    vecs[1]  = '{0, 0,  64'h0,    0, 0,  3,  3,  64'h1234, 64'h1234, 0, 0, 64'h1234, 64'h1234, 0, 0};
    vecs[2]  = '{1, 0,  64'hFFFF, 1, 0,  0,  0,  64'h0,    64'h0,    0, 0, 64'h0,    64'h0,    0, 0};
    vecs[3]  = '{0, 0,  64'h0,    0, 0,  0,  0,  64'h0,    64'h0,    0, 0, 64'hFFFF, 64'hFFFF, 1, 1};
    vecs[4]  = '{0, 0,  64'h0,    1, 7,  0,  7,  64'h0,    64'h0,    0, 0, 64'hFFFF, 64'h0,    1, 0};
    vecs[5]  = '{0, 0,  64'h0,    0, 0,  0,  7,  64'h0,    64'h0,    0, 1, 64'hFFFF, 64'h0,    1, 1};
    vecs[6]  = '{1, 7,  64'h9,    0, 0,  0,  7,  64'h0,    64'h9,    0, 0, 64'hFFFF, 64'h0,    1, 1};
    vecs[7]  = '{0, 0,  64'h0,    0, 0,  0,  7,  64'h0,    64'h9,    0, 0, 64'hFFFF, 64'h9,    1, 0};
    vecs[8]  = '{0, 0,  64'h0,    1, 4,  4,  3,  64'h0,    64'h1234, 0, 0, 64'h0,    64'h1234, 0, 0};
    vecs[9]  = '{1, 4,  64'h55,   1, 4,  4,  4,  64'h55,   64'h55,   0, 0, 64'h0,    64'h0,    1, 1};
    vecs[10] = '{0, 0,  64'h0,    0, 0,  4,  3,  64'h55,   64'h1234, 1, 0, 64'h55,   64'h1234, 1, 0};
    vecs[11] = '{1, 30, 64'hABC,  1, 30, 30, 30, 64'hABC,  64'hABC,  0, 0, 64'h0,    64'h0,    0, 0};
    vecs[12] = '{0, 0,  64'h0,    0, 0,  30, 24, 64'hABC,  64'h0,    1, 0, 64'h0,    64'h0,    0, 0};
    vecs[13] = '{1, 24, 64'h77,   0, 0,  24, 31, 64'h77,   64'h0,    0, 0, 64'h0,    64'h0,    0, 0};
    vecs[14] = '{0, 0,  64'h0,    0, 0,  24, 4,  64'h77,   64'h55,   0, 1, 64'h0,    64'h55,   0, 1};
    vecs[15] = '{1, 4,  64'h66,   0, 0,  4,  4,  64'h66,   64'h66,   0, 0, 64'h55,   64'h55,   1, 1};
    vecs[16] = '{0, 0,  64'h0,    0, 0,  4,  7,  64'h66,   64'h9,    0, 0, 64'h66,   64'h9,    0, 0};

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 5, 3);
    #12;
    checkOutput("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iss, vecs[i].ia,
                    vecs[i].r1, vecs[i].r2);
      #2;
      checkOutput($sformatf("vec%0d", i), vecs[i].a1, vecs[i].a2, vecs[i].ap1, vecs[i].ap2,
                  vecs[i].b1, vecs[i].b2, vecs[i].bp1, vecs[i].bp2);
    end

    // Asynchronous reset mid-cycle wipes data and scoreboard
    @(negedge clk);
    applyStimulus(1, 5, 64'hDEAD, 1, 5, 5, 5);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 5, 5);
    #2;
    checkOutput("r5_before_reset", 64'hDEAD, 64'hDEAD, 1, 1, 64'hDEAD, 64'hDEAD, 1, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("r5_during_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checkOutput("r5_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 64'h42, 0, 0, 5, 5);
    #1;
    checkOutput("first_write_bypass", 64'h42, 64'h42, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 5, 5);
    #2;
    checkOutput("first_write_landed", 64'h42, 64'h42, 0, 0, 64'h42, 64'h42, 0, 0);

    // Random regression against the reference model
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    clearModel();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      applyStimulus(1'($urandom_range(0, 1)), randAddr(), {$urandom, $urandom},
                    1'($urandom_range(0, 2) == 0), randAddr(),
                    ($urandom_range(0, 2) == 0) ? wa : randAddr(), randAddr());
      #2;
      modelRead(32, 1, 1, m_ra, m_pa, ra1, e1a, q1a);
      modelRead(32, 1, 1, m_ra, m_pa, ra2, e2a, q2a);
      modelRead(24, 0, 0, m_rb, m_pb, ra1, e1b, q1b);
      modelRead(24, 0, 0, m_rb, m_pb, ra2, e2b, q2b);
      checkOutput($sformatf("rand%0d", c), e1a, e2a, q1a, q2a, e1b, e2b, q1b, q2b);
      if (we && wa != 0) begin
        m_ra[wa] = wd; m_pa[wa] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_pa[iss_addr] = 1'b1;
      if (we && wa < 24) begin
        m_rb[wa] = wd; m_pb[wa] = 1'b0;
      end
      if (iss_en && iss_addr < 24) m_pb[iss_addr] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
